// File: rtl/trace_arbiter.sv
`timescale 1ns/1ps
// trace_arbiter: round-robin arbiter sharing one registered trace FIFO write stage among num_src_p sources.
// Defining TRACE_ARB_PRIO_EN gives source 0 strict priority over a round-robin among sources 1..N-1.
module trace_arbiter #(
  parameter int num_src_p    = 4,
  parameter int data_width_p = 5,
  parameter int id_width_p   = $clog2(num_src_p)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              trace_en,
  input  logic [num_src_p-1:0]              src_en,
  input  logic [num_src_p*data_width_p-1:0] in_data,
  input  logic [num_src_p-1:0]              in_valid,
  output logic [num_src_p-1:0]              in_ready,
  output logic [data_width_p-1:0]           fifo_data,
  output logic [id_width_p-1:0]             fifo_id,
  output logic                              fifo_valid,
  input  logic                              fifo_ready
);

  localparam logic [id_width_p:0]   num_src_w_lp = (id_width_p+1)'(num_src_p);
  localparam logic [id_width_p:0]   num_m1_w_lp  = (id_width_p+1)'(num_src_p - 1);
  localparam logic [id_width_p-1:0] last_idx_lp  = id_width_p'(num_src_p - 1);

  logic                    load_s;
  logic                    found_s;
  logic                    hit_s;
  logic                    grant_s;
  logic [num_src_p-1:0]    elig_s;
  logic [id_width_p:0]     cand_s;
  logic [id_width_p-1:0]   start_s;
  logic [id_width_p-1:0]   grant_idx_s;
  logic [id_width_p-1:0]   rr_next_s;
  logic [id_width_p-1:0]   rr_ptr_r;
  logic [data_width_p-1:0] grant_word_s;

  // Grant search: first eligible source at or after rr_ptr_r, wrapping.
  always_comb begin
    load_s      = !fifo_valid || fifo_ready;
    elig_s      = in_valid & src_en & {num_src_p{trace_en}};
    found_s     = 1'b0;
    hit_s       = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
`ifdef TRACE_ARB_PRIO_EN
    // Pointer is confined to 1..N-1; the reset value 0 behaves as 1.
    start_s = (rr_ptr_r == '0) ? id_width_p'(1) : rr_ptr_r;
    for (int k = 0; k < num_src_p - 1; k++) begin
      cand_s      = {1'b0, start_s} + (id_width_p+1)'(k);
      cand_s      = (cand_s >= num_src_w_lp) ? cand_s - num_m1_w_lp : cand_s;
      hit_s       = !found_s && elig_s[cand_s[id_width_p-1:0]];
      grant_idx_s = hit_s ? cand_s[id_width_p-1:0] : grant_idx_s;
      found_s     = found_s || hit_s;
    end
    grant_idx_s = elig_s[0] ? '0 : grant_idx_s;
    found_s     = found_s || elig_s[0];
    rr_next_s   = elig_s[0] ? rr_ptr_r :
                  (grant_idx_s == last_idx_lp) ? id_width_p'(1) : grant_idx_s + id_width_p'(1);
`else
    start_s = rr_ptr_r;
    for (int k = 0; k < num_src_p; k++) begin
      cand_s      = {1'b0, start_s} + (id_width_p+1)'(k);
      cand_s      = (cand_s >= num_src_w_lp) ? cand_s - num_src_w_lp : cand_s;
      hit_s       = !found_s && elig_s[cand_s[id_width_p-1:0]];
      grant_idx_s = hit_s ? cand_s[id_width_p-1:0] : grant_idx_s;
      found_s     = found_s || hit_s;
    end
    rr_next_s = (grant_idx_s == last_idx_lp) ? '0 : grant_idx_s + id_width_p'(1);
`endif
    grant_s = load_s && found_s && !rst;
  end

  // One-hot ready and word mux for the granted source.
  always_comb begin
    grant_word_s = '0;
    in_ready     = '0;
    for (int i = 0; i < num_src_p; i++) begin
      in_ready[i]  = grant_s && (grant_idx_s == id_width_p'(i));
      grant_word_s = (grant_idx_s == id_width_p'(i)) ? in_data[i*data_width_p +: data_width_p]
                                                      : grant_word_s;
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_valid <= 1'b0;
      fifo_data  <= '0;
      fifo_id    <= '0;
      rr_ptr_r   <= '0;
    end else if (grant_s) begin
      fifo_valid <= 1'b1;
      fifo_data  <= grant_word_s;
      fifo_id    <= grant_idx_s;
      rr_ptr_r   <= rr_next_s;
    end else if (fifo_ready) begin
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= fifo_valid;
    end
  end

endmodule

// File: tb/tb_trace_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for trace_arbiter: directed scenarios plus randomized traffic against a queue-free
// behavioural model that searches sources with modulo arithmetic.
module tb_trace_arbiter;
  localparam int N  = 4;
  localparam int DW = 5;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            trace_en;
  logic [N-1:0]    src_en;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   fifo_data;
  logic [IW-1:0]   fifo_id;
  logic            fifo_valid;
  logic            fifo_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int            m_ptr   = 0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_id    = 0;

  always #5 clk = ~clk;

  trace_arbiter #(.num_src_p(N), .data_width_p(DW), .id_width_p(IW)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .src_en(src_en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .fifo_data(fifo_data), .fifo_id(fifo_id),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready)
  );

  function automatic bit elig(int i);
    return trace_en && src_en[i] && in_valid[i];
  endfunction

  function automatic int model_grant();
    int s;
    if (rst) return -1;
    if (m_valid && !fifo_ready) return -1;
`ifdef TRACE_ARB_PRIO_EN
    if (elig(0)) return 0;
    s = (m_ptr == 0) ? 1 : m_ptr;
    for (int k = 0; k < N - 1; k++)
      if (elig(1 + (s - 1 + k) % (N - 1))) return 1 + (s - 1 + k) % (N - 1);
`else
    s = m_ptr;
    for (int k = 0; k < N; k++)
      if (elig((s + k) % N)) return (s + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] one;
    g = model_grant();
    one = {{(N-1){1'b0}}, 1'b1};
    return (g < 0) ? '0 : (one << g);
  endfunction

  task automatic advance();
    int g;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0;
    end else if (g >= 0) begin
      m_data  = in_data[g*DW +: DW];
      m_id    = g;
      m_valid = 1'b1;
`ifdef TRACE_ARB_PRIO_EN
      if (g != 0) m_ptr = (g == N - 1) ? 1 : g + 1;
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (fifo_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; trace_en = 1'b1; src_en = '1; in_valid = '1; fifo_ready = 1'b1;
    in_data = {5'h04, 5'h03, 5'h02, 5'h01};
    for (int c = 0; c < 2; c++) begin
      advance();
      n_cmp++;
      if (fifo_valid !== 1'b0 || fifo_id !== 2'd0 || fifo_data !== 5'h00 || in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b id=%0d data=%h ready=%b want 0/0/00/0000",
                 fifo_valid, fifo_id, fifo_data, in_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: ready=%b want 0001", in_ready);
    end
  endtask

  task automatic test_rotation();
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL rotation_ready: cycle %0d ready=%b want %b", c, in_ready, exp_ready());
      end
      advance();
      n_cmp++;
      if (fifo_valid !== 1'b1 || int'(fifo_id) != m_id || fifo_data !== m_data) begin
        n_fail++;
        $display("FAIL rotation_out: cycle %0d id=%0d data=%h valid=%b want %0d/%h/1",
                 c, fifo_id, fifo_data, fifo_valid, m_id, m_data);
      end
`ifndef TRACE_ARB_PRIO_EN
      n_cmp++;
      if (int'(fifo_id) != exp_ids[c] || fifo_data !== DW'(exp_ids[c] + 1)) begin
        n_fail++;
        $display("FAIL rotation_seq: cycle %0d id=%0d data=%h want %0d/%h",
                 c, fifo_id, fifo_data, exp_ids[c], exp_ids[c] + 1);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    advance();
`ifndef TRACE_ARB_PRIO_EN
    n_cmp++;
    if (fifo_id !== 2'd1 || fifo_data !== 5'h02) begin
      n_fail++;
      $display("FAIL bp_load: id=%0d data=%h want 1/02", fifo_id, fifo_data);
    end
`endif
    fifo_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_data = N*DW'($urandom);
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000 || fifo_valid !== 1'b1 || int'(fifo_id) != m_id || fifo_data !== m_data) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d ready=%b valid=%b id=%0d data=%h want 0000/1/%0d/%h",
                 c, in_ready, fifo_valid, fifo_id, fifo_data, m_id, m_data);
      end
      advance();
    end
    fifo_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== exp_ready()) begin
      n_fail++;
      $display("FAIL bp_resume_ready: ready=%b want %b", in_ready, exp_ready());
    end
`ifndef TRACE_ARB_PRIO_EN
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_next_src2: ready=%b want 0100", in_ready);
    end
`endif
    advance();
    n_cmp++;
    if (int'(fifo_id) != m_id || fifo_data !== m_data || fifo_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume_out: id=%0d data=%h want %0d/%h", fifo_id, fifo_data, m_id, m_data);
    end
  endtask

  task automatic test_masking();
    int exp_ids[4] = '{3, 1, 3, 1};
    src_en = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      in_data = N*DW'($urandom);
      #1;
      advance();
      n_cmp++;
      if (int'(fifo_id) != m_id || fifo_data !== m_data || fifo_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_out: cycle %0d id=%0d data=%h want %0d/%h", c, fifo_id, fifo_data, m_id, m_data);
      end
`ifndef TRACE_ARB_PRIO_EN
      n_cmp++;
      if (int'(fifo_id) != exp_ids[c]) begin
        n_fail++;
        $display("FAIL mask_seq: cycle %0d id=%0d want %0d", c, fifo_id, exp_ids[c]);
      end
`endif
    end
    trace_en = 1'b0; fifo_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000 || fifo_valid !== 1'b1 || int'(fifo_id) != m_id) begin
        n_fail++;
        $display("FAIL mask_trace_off_hold: ready=%b valid=%b id=%0d want 0000/1/%0d",
                 in_ready, fifo_valid, fifo_id, m_id);
      end
      advance();
    end
    fifo_ready = 1'b1;
    advance();
    n_cmp++;
    if (fifo_valid !== 1'b0 || int'(fifo_id) != m_id || fifo_data !== m_data) begin
      n_fail++;
      $display("FAIL mask_drain: valid=%b id=%0d data=%h want 0/%0d/%h", fifo_valid, fifo_id, fifo_data, m_id, m_data);
    end
  endtask

  task automatic test_sparse();
    int exp_ids[5] = '{2, 2, 2, 3, 0};
    trace_en = 1'b1; src_en = '1; in_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) in_valid = 4'b1001;
      in_data = N*DW'($urandom);
      #1;
      advance();
      n_cmp++;
      if (int'(fifo_id) != m_id || fifo_data !== m_data || fifo_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sparse_out: cycle %0d id=%0d data=%h want %0d/%h", c, fifo_id, fifo_data, m_id, m_data);
      end
`ifndef TRACE_ARB_PRIO_EN
      n_cmp++;
      if (int'(fifo_id) != exp_ids[c]) begin
        n_fail++;
        $display("FAIL sparse_seq: cycle %0d id=%0d want %0d", c, fifo_id, exp_ids[c]);
      end
`endif
    end
  endtask

`ifdef TRACE_ARB_PRIO_EN
  task automatic test_prio();
    in_valid = 4'b0101; src_en = '1; trace_en = 1'b1; fifo_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) in_valid = 4'b0100;
      #1;
      advance();
      n_cmp++;
      if (int'(fifo_id) != ((c == 4) ? 2 : 0)) begin
        n_fail++;
        $display("FAIL prio_seq: cycle %0d id=%0d want %0d", c, fifo_id, (c == 4) ? 2 : 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      trace_en   = ($urandom_range(0, 9) != 0);
      src_en     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      in_valid   = N'($urandom);
      in_data    = N*DW'($urandom);
      fifo_ready = ($urandom_range(0, 9) < 7);
      #1;
      n_cmp++;
      if (in_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL rand_ready: cycle %0d ready=%b want %b", c, in_ready, exp_ready());
      end
      advance();
      n_cmp++;
      if (fifo_valid !== m_valid || int'(fifo_id) != m_id || fifo_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_out: cycle %0d valid=%b id=%0d data=%h want %b/%0d/%h",
                 c, fifo_valid, fifo_id, fifo_data, m_valid, m_id, m_data);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_masking();
    test_sparse();
`ifdef TRACE_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
